// File: rtl/y86_pkg.sv
// Shared Y86 status codes, icodes and memory-op decode helpers.
package y86_pkg;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] INOP   = 4'h1;
    localparam logic [3:0] ICMOV  = 4'h2;
    localparam logic [3:0] IRMMOV = 4'h4;
    localparam logic [3:0] IMRMOV = 4'h5;
    localparam logic [3:0] ICALL  = 4'h8;
    localparam logic [3:0] IRET   = 4'h9;
    localparam logic [3:0] IPUSH  = 4'hA;
    localparam logic [3:0] IPOP   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;

    // Instructions that load a word from data memory.
    function automatic logic is_mem_read(input logic [3:0] icode);
        return icode inside {IMRMOV, IRET, IPOP};
    endfunction

    // Instructions that store a word to data memory.
    function automatic logic is_mem_write(input logic [3:0] icode);
        return icode inside {IRMMOV, ICALL, IPUSH};
    endfunction

    // Stack pops take their address from valA instead of valE.
    function automatic logic addr_sel_valA(input logic [3:0] icode);
        return icode inside {IRET, IPOP};
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Word-indexed data RAM: synchronous write, asynchronous read, no reset.
module mem_stage_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Commit a store at the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[idx];

endmodule

// File: rtl/mem_stage_param.sv
// Y86 memory stage: RAM access with optional wait states, status and cmov handling.
module mem_stage_param
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [2:0]        M_stat,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    output logic              m_stall,
    output logic              m_valid,
    output logic [3:0]        m_icode,
    output logic [2:0]        m_stat,
    output logic [DATA_W-1:0] m_valE,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic        HAS_WAIT = (WAIT_CYCLES > 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cap_icode_q, cap_icode_d;
    logic [DATA_W-1:0] cap_valE_q, cap_valE_d;
    logic [DATA_W-1:0] cap_valA_q, cap_valA_d;
    logic [3:0]        cap_dstE_q, cap_dstE_d;
    logic [3:0]        cap_dstM_q, cap_dstM_d;

    logic              m_valid_q, m_valid_d;
    logic [3:0]        m_icode_q, m_icode_d;
    logic [2:0]        m_stat_q, m_stat_d;
    logic [DATA_W-1:0] m_valE_q, m_valE_d;
    logic [DATA_W-1:0] m_valM_q, m_valM_d;
    logic [3:0]        m_dstE_q, m_dstE_d;
    logic [3:0]        m_dstM_q, m_dstM_d;

    logic              busy;
    logic [3:0]        req_icode;
    logic              req_cnd;
    logic [2:0]        req_stat;
    logic [DATA_W-1:0] req_valE, req_valA, req_addr;
    logic [3:0]        req_dstE, req_dstM;
    logic              req_rd, req_wr, addr_err, req_ok, complete, wr_en;
    logic [DATA_W-1:0] ram_rd_data;

    // Active request: the captured one while waiting, else the live M register.
    always_comb begin
        busy      = (state_q == BUSY);
        req_icode = busy ? cap_icode_q : M_icode;
        req_cnd   = busy ? 1'b1        : M_cnd;
        req_stat  = busy ? SAOK        : M_stat;
        req_valE  = busy ? cap_valE_q  : M_valE;
        req_valA  = busy ? cap_valA_q  : M_valA;
        req_dstE  = busy ? cap_dstE_q  : M_dstE;
        req_dstM  = busy ? cap_dstM_q  : M_dstM;
        req_rd    = is_mem_read(req_icode);
        req_wr    = is_mem_write(req_icode);
        req_addr  = addr_sel_valA(req_icode) ? req_valA : req_valE;
        addr_err  = (req_rd || req_wr) && (req_addr >= DATA_W'(DEPTH));
        req_ok    = (req_stat == SAOK) && !addr_err;
    end

    // Next-state, wait counter, request capture and W-side outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_icode_d = cap_icode_q;
        cap_valE_d  = cap_valE_q;
        cap_valA_d  = cap_valA_q;
        cap_dstE_d  = cap_dstE_q;
        cap_dstM_d  = cap_dstM_q;
        m_valid_d   = 1'b0;
        m_icode_d   = INOP;
        m_stat_d    = m_stat_q;
        m_valE_d    = m_valE_q;
        m_valM_d    = m_valM_q;
        m_dstE_d    = RNONE;
        m_dstM_d    = RNONE;
        complete    = 1'b0;
        wr_en       = 1'b0;

        if (state_q == IDLE) begin
            if (M_valid) begin
                if (HAS_WAIT && req_ok && (req_rd || req_wr)) begin
                    state_d     = BUSY;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    cap_icode_d = M_icode;
                    cap_valE_d  = M_valE;
                    cap_valA_d  = M_valA;
                    cap_dstE_d  = M_dstE;
                    cap_dstM_d  = M_dstM;
                end else begin
                    complete = 1'b1;
                end
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                complete = 1'b1;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (complete) begin
            m_valid_d = 1'b1;
            m_icode_d = req_icode;
            m_stat_d  = addr_err && (req_stat == SAOK) ? SADR : req_stat;
            m_valE_d  = req_valE;
            m_valM_d  = (req_ok && req_rd) ? ram_rd_data : '0;
            m_dstE_d  = ((req_icode == ICMOV) && !req_cnd) ? RNONE : req_dstE;
            m_dstM_d  = req_dstM;
            wr_en     = req_ok && req_wr;
        end
    end

    // State and output registers; a reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_icode_q <= INOP;
            cap_valE_q  <= '0;
            cap_valA_q  <= '0;
            cap_dstE_q  <= RNONE;
            cap_dstM_q  <= RNONE;
            m_valid_q   <= 1'b0;
            m_icode_q   <= INOP;
            m_stat_q    <= SAOK;
            m_valE_q    <= '0;
            m_valM_q    <= '0;
            m_dstE_q    <= RNONE;
            m_dstM_q    <= RNONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_icode_q <= cap_icode_d;
            cap_valE_q  <= cap_valE_d;
            cap_valA_q  <= cap_valA_d;
            cap_dstE_q  <= cap_dstE_d;
            cap_dstM_q  <= cap_dstM_d;
            m_valid_q   <= m_valid_d;
            m_icode_q   <= m_icode_d;
            m_stat_q    <= m_stat_d;
            m_valE_q    <= m_valE_d;
            m_valM_q    <= m_valM_d;
            m_dstE_q    <= m_dstE_d;
            m_dstM_q    <= m_dstM_d;
        end
    end

    mem_stage_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .idx     (req_addr[IDX_W-1:0]),
        .wr_data (req_valA),
        .rd_data (ram_rd_data)
    );

    assign m_stall = (state_q == BUSY);
    assign m_valid = m_valid_q;
    assign m_icode = m_icode_q;
    assign m_stat  = m_stat_q;
    assign m_valE  = m_valE_q;
    assign m_valM  = m_valM_q;
    assign m_dstE  = m_dstE_q;
    assign m_dstM  = m_dstM_q;

endmodule

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
- Parametrised Y86 pipeline memory stage, sitting between the M and W pipeline registers.
- Serves data-memory reads and writes from a word-indexed RAM with configurable width, depth and access wait states.
- Registers its results toward writeback. Stalls upstream while a multi-cycle access is in flight.
- Adds status propagation, address-error detection, exception write suppression and cmov destination cancel.

Parameters:
- DATA_W, 64, data word width (valE, valA, valM, RAM word).
- DEPTH, 1024, number of RAM words. Valid word indices are 0..DEPTH-1.
- WAIT_CYCLES, 2, extra cycles per legal memory access. 0 means single-cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- M_valid  in  1  M register holds a real instruction.
- M_icode  in  4  instruction code.
- M_cnd  in  1  condition flag from execute.
- M_stat  in  3  incoming status.
- M_valE  in  DATA_W  ALU result / address.
- M_valA  in  DATA_W  store data / stack address.
- M_dstE  in  4  E destination register.
- M_dstM  in  4  M destination register.
- m_stall  out  1  request not accepted this cycle; upstream must hold M_* stable.
- m_valid  out  1  W-side outputs carry a completed instruction.
- m_icode  out  4  completed icode.
- m_stat  out  3  completed status.
- m_valE  out  DATA_W  passed-through valE.
- m_valM  out  DATA_W  read data.
- m_dstE  out  4  completed E destination.
- m_dstM  out  4  completed M destination.

Behaviour:
- Shared codes:
  - Status: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - Icodes: INOP=1, ICMOV=2, RMMOV=4, MRMOV=5, CALL=8, RET=9, PUSH=A, POP=B.
  - RNONE=F.
- Operation decode:
  - Read ops: 5, 9, B.
  - Write ops: 4, 8, A.
  - Address is valE for 4, 5, 8, A; valA for 9, B.
  - The full DATA_W address is compared unsigned against DEPTH. addr >= DEPTH is an address error.
- Reset (async, active-high):
  - FSM goes to IDLE. m_stall=0, m_valid=0, m_icode=INOP, m_stat=SAOK, m_valE=0, m_valM=0, m_dstE=RNONE, m_dstM=RNONE.
  - The RAM array is not reset.
  - Reset during BUSY drops the pending access; a pending write never commits.
- FSM states: IDLE, BUSY. m_stall = (state==BUSY), driven from registered state only.
- IDLE, M_valid=1, then at the clock edge:
  - Legal memory op (M_stat==SAOK, no address error, WAIT_CYCLES>0): capture the request internally, load wait counter with WAIT_CYCLES, go to BUSY, set m_valid=0.
  - Any other case completes at this edge. This covers non-memory ops, WAIT_CYCLES=0, address errors and M_stat!=SAOK.
- BUSY:
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, completion occurs at the edge and the FSM returns to IDLE.
  - m_stall deasserts the cycle after completion.
  - Legal-access latency is WAIT_CYCLES+1 edges from acceptance to m_valid.
- Completion at the edge:
  - m_valid=1.
  - m_icode, m_valE, m_dstM are copied from the captured or current request.
  - m_stat: SADR if address error and incoming stat was SAOK; otherwise the incoming stat.
  - m_valM: RAM[addr] for a legal read; 0 otherwise, including errors.
  - Legal write: RAM[addr] <= valA at the same edge.
  - m_dstE: RNONE if icode==ICMOV and M_cnd==0; otherwise M_dstE.
- Writes are suppressed whenever M_stat != SAOK or an address error occurs. This keeps an exception in flight from modifying memory.
- No completion in a cycle (idle or waiting):
  - m_valid=0, m_icode=INOP, m_dstE=RNONE, m_dstM=RNONE (bubble).
  - m_stat, m_valE, m_valM hold their values.
- Back-to-back ordering:
  - A write commits before the next request is accepted.
  - A read of the same address in the following instruction returns the new data; no bypass is needed.
- IDLE with M_valid=0: a bubble is emitted.

Decomposition:
- Package y86_pkg: status codes, icode constants, RNONE, and the functions is_mem_read(icode), is_mem_write(icode) and addr_sel_valA(icode).
- One sub-module, mem_stage_ram: DEPTH x DATA_W array with a synchronous write port and an asynchronous read port, index width $clog2(DEPTH).
- The FSM, counter and output registers live in the top level.

Test Plan:
- WAIT_CYCLES=2: RMMOV (valE=8, valA=0xDEAD), then MRMOV (valE=8).
  - Each access: m_stall high 2 cycles, m_valid on the 3rd edge.
  - Second instruction completes with m_valM=0xDEAD, m_stat=1.
- MRMOV with valE=1024 (DEPTH=1024): no stall, completes next edge with m_stat=3, m_valM=0, RAM unchanged.
- PUSH with M_stat=4 (SINS): no write to RAM[valE], m_stat=4, no stall.
- ICMOV with M_cnd=0, dstE=3: m_dstE=F. With M_cnd=1: m_dstE=3. Both complete in 1 cycle with no stall.
- Reset asserted mid-BUSY of RMMOV (valE=5, valA=0x55), RAM[5] preloaded with 0x11:
  - Outputs reset immediately: m_stall=0, m_valid=0.
  - A later MRMOV from address 5 reads 0x11.
- WAIT_CYCLES=0 build: alternating CALL/RET to the same stack address returns the pushed value, one instruction per cycle, m_stall always 0.
